store_pair_buffer: RTL and testbench

- Elastic pairing stage that sits directly upstream of the loadless memory controller's store port.
- Accepts store address and store data on independent handshake channels, which may arrive in different cycles or at different rates.
- Buffers each channel in its own circular FIFO.
- Presents a store to the controller only when both heads are present, so the controller's single-valid store arbitration always sees an aligned address/data pair.

---
 rtl/store_pair_buffer_if.sv | 33 +++
 rtl/store_pair_buffer.sv | 92 +++++++++
 tb/tb_store_pair_buffer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/store_pair_buffer_if.sv
// Handshake bundle for the store pairing stage: producer address/data channels
// in, aligned address/data pair out to the memory controller's store port.
interface store_pair_buffer_if #(
  parameter int ADDR_TYPE = 32,
  parameter int DATA_TYPE = 32
);
  logic [ADDR_TYPE-1:0] addrIn;
  logic                 addrIn_valid;
  logic                 addrIn_ready;
  logic [DATA_TYPE-1:0] dataIn;
  logic                 dataIn_valid;
  logic                 dataIn_ready;
  logic [ADDR_TYPE-1:0] stAddr;
  logic                 stAddr_valid;
  logic                 stAddr_ready;
  logic [DATA_TYPE-1:0] stData;
  logic                 stData_valid;
  logic                 stData_ready;

  modport master (
    output addrIn, addrIn_valid, input addrIn_ready,
    output dataIn, dataIn_valid, input dataIn_ready,
    input  stAddr, stAddr_valid, output stAddr_ready,
    input  stData, stData_valid, output stData_ready
  );

  modport slave (
    input  addrIn, addrIn_valid, output addrIn_ready,
    input  dataIn, dataIn_valid, output dataIn_ready,
    output stAddr, stAddr_valid, input stAddr_ready,
    output stData, stData_valid, input stData_ready
  );
endinterface

// File: rtl/store_pair_buffer.sv
// Elastic pairing stage: independent address/data FIFOs whose heads are only
// presented (and popped together) when both channels hold an entry.
module store_pair_buffer #(
  parameter int ADDR_TYPE = 32,
  parameter int DATA_TYPE = 32,
  parameter int DEPTH     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  store_pair_buffer_if.slave             st_if,
  output logic [$clog2(DEPTH+1)-1:0]     pairCount
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ADDR_TYPE-1:0] r_addr_mem [DEPTH];
  logic [DATA_TYPE-1:0] r_data_mem [DEPTH];

  logic [PW-1:0] r_addr_head, r_addr_tail;
  logic [PW-1:0] r_data_head, r_data_tail;
  logic [CW-1:0] r_addr_cnt, r_data_cnt;
  logic [CW-1:0] r_pair_cnt;

  logic          w_addr_ready, w_data_ready;
  logic          w_addr_push, w_data_push;
  logic          w_valid, w_pop;
  logic [CW-1:0] w_addr_cnt_nxt, w_data_cnt_nxt, w_pair_nxt;

  // Readiness depends only on own occupancy, so a full FIFO refuses even when popping.
  assign w_addr_ready = !rst && (r_addr_cnt < FULL);
  assign w_data_ready = !rst && (r_data_cnt < FULL);
  assign w_addr_push  = st_if.addrIn_valid && w_addr_ready;
  assign w_data_push  = st_if.dataIn_valid && w_data_ready;

  assign w_valid = !rst && (r_addr_cnt != '0) && (r_data_cnt != '0);
  assign w_pop   = w_valid && st_if.stAddr_ready && st_if.stData_ready;

  assign st_if.addrIn_ready = w_addr_ready;
  assign st_if.dataIn_ready = w_data_ready;
  assign st_if.stAddr_valid = w_valid;
  assign st_if.stData_valid = w_valid;
  assign st_if.stAddr       = w_valid ? r_addr_mem[r_addr_head] : '0;
  assign st_if.stData       = w_valid ? r_data_mem[r_data_head] : '0;
  assign pairCount          = rst ? '0 : r_pair_cnt;

  always_comb begin
    w_addr_cnt_nxt = r_addr_cnt;
    w_data_cnt_nxt = r_data_cnt;
    case ({w_addr_push, w_pop})
      2'b10:   w_addr_cnt_nxt = r_addr_cnt + CW'(1);
      2'b01:   w_addr_cnt_nxt = r_addr_cnt - CW'(1);
      default: w_addr_cnt_nxt = r_addr_cnt;
    endcase
    case ({w_data_push, w_pop})
      2'b10:   w_data_cnt_nxt = r_data_cnt + CW'(1);
      2'b01:   w_data_cnt_nxt = r_data_cnt - CW'(1);
      default: w_data_cnt_nxt = r_data_cnt;
    endcase
    w_pair_nxt = (w_addr_cnt_nxt < w_data_cnt_nxt) ? w_addr_cnt_nxt : w_data_cnt_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_addr_push) r_addr_mem[r_addr_tail] <= st_if.addrIn;
    if (w_data_push) r_data_mem[r_data_tail] <= st_if.dataIn;
  end

  // Pointers are PW bits and DEPTH is a power of two, so increments wrap for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_head <= '0;
      r_addr_tail <= '0;
      r_data_head <= '0;
      r_data_tail <= '0;
      r_addr_cnt  <= '0;
      r_data_cnt  <= '0;
      r_pair_cnt  <= '0;
    end else begin
      if (w_addr_push) r_addr_tail <= r_addr_tail + PW'(1);
      if (w_data_push) r_data_tail <= r_data_tail + PW'(1);
      if (w_pop) begin
        r_addr_head <= r_addr_head + PW'(1);
        r_data_head <= r_data_head + PW'(1);
      end
      r_addr_cnt <= w_addr_cnt_nxt;
      r_data_cnt <= w_data_cnt_nxt;
      r_pair_cnt <= w_pair_nxt;
    end
  end

endmodule

// File: tb/tb_store_pair_buffer.sv
// Directed bench for store_pair_buffer: queue-based model checked every cycle,
// plus literal expectations on the pairs delivered to the controller.
module tb_store_pair_buffer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] pairCount;
  logic       chk_en = 1'b0;

  int total = 0;
  int bad   = 0;

  store_pair_buffer_if #(.ADDR_TYPE(32), .DATA_TYPE(32)) bus();

  store_pair_buffer #(.ADDR_TYPE(32), .DATA_TYPE(32), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .st_if    (bus.slave),
    .pairCount(pairCount)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: two unbounded-style queues capped at DEPTH.
  logic [31:0] aq[$];
  logic [31:0] dq[$];
  int          m_pair = 0;

  always @(posedge clk) begin
    if (rst) begin
      aq.delete();
      dq.delete();
      m_pair = 0;
    end else begin
      bit apush, dpush, pop;
      apush = bus.addrIn_valid && (aq.size() < DEPTH);
      dpush = bus.dataIn_valid && (dq.size() < DEPTH);
      pop   = (aq.size() > 0) && (dq.size() > 0) && bus.stAddr_ready && bus.stData_ready;
      if (pop) begin
        void'(aq.pop_front());
        void'(dq.pop_front());
      end
      if (apush) aq.push_back(bus.addrIn);
      if (dpush) dq.push_back(bus.dataIn);
      m_pair = (aq.size() < dq.size()) ? aq.size() : dq.size();
    end
  end

  logic [63:0] pops[$];
  int          vcount = 0;
  int          max_pc = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      bit          ev;
      logic [31:0] ea, ed;
      ev = !rst && (aq.size() > 0) && (dq.size() > 0);
      ea = ev ? aq[0] : 32'h0;
      ed = ev ? dq[0] : 32'h0;
      chk("stAddr_valid", {63'h0, bus.stAddr_valid}, {63'h0, ev});
      chk("stData_valid", {63'h0, bus.stData_valid}, {63'h0, ev});
      chk("stAddr", {32'h0, bus.stAddr}, {32'h0, ea});
      chk("stData", {32'h0, bus.stData}, {32'h0, ed});
      chk("addrIn_ready", {63'h0, bus.addrIn_ready}, {63'h0, !rst && (aq.size() < DEPTH)});
      chk("dataIn_ready", {63'h0, bus.dataIn_ready}, {63'h0, !rst && (dq.size() < DEPTH)});
      chk("pairCount", {61'h0, pairCount}, rst ? 64'd0 : 64'(m_pair));
      if (bus.stAddr_valid) vcount++;
      if (int'(pairCount) > max_pc) max_pc = int'(pairCount);
      if (bus.stAddr_valid && bus.stAddr_ready && bus.stData_ready)
        pops.push_back({bus.stAddr, bus.stData});
    end
  end

  task automatic step(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    pops.delete();
    vcount = 0;
    max_pc = 0;
  endtask

  task automatic chk_pops(string name, int idx, logic [31:0] a, logic [31:0] d);
    logic [63:0] got;
    got = (idx < pops.size()) ? pops[idx] : 64'hDEAD_DEAD_DEAD_DEAD;
    chk(name, got, {a, d});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.addrIn = '0; bus.addrIn_valid = 1'b0;
    bus.dataIn = '0; bus.dataIn_valid = 1'b0;
    bus.stAddr_ready = 1'b0; bus.stData_ready = 1'b0;
    step(2);
    chk_en = 1'b1;
    chk("rst_pairCount", {61'h0, pairCount}, 64'd0);
    chk("rst_addr_ready", {63'h0, bus.addrIn_ready}, 64'd0);
    rst = 1'b0;
    step();
    chk("post_rst_valid", {63'h0, bus.stAddr_valid}, 64'd0);
    chk("post_rst_stAddr", {32'h0, bus.stAddr}, 64'd0);
    chk("post_rst_ready", {62'h0, bus.addrIn_ready, bus.dataIn_ready}, 64'd3);

    // Aligned stream
    clear_log();
    bus.stAddr_ready = 1'b1; bus.stData_ready = 1'b1;
    bus.addrIn = 32'h10; bus.dataIn = 32'hAA; bus.addrIn_valid = 1'b1; bus.dataIn_valid = 1'b1;
    step();
    bus.addrIn = 32'h14; bus.dataIn = 32'hBB;
    step();
    bus.addrIn_valid = 1'b0; bus.dataIn_valid = 1'b0;
    step(3);
    chk("aligned_n", 64'(pops.size()), 64'd2);
    chk_pops("aligned_p0", 0, 32'h10, 32'hAA);
    chk_pops("aligned_p1", 1, 32'h14, 32'hBB);
    chk("aligned_vcyc", 64'(vcount), 64'd2);

    // Skew: addresses run ahead, data follows later
    clear_log();
    for (int i = 0; i < 3; i++) begin
      bus.addrIn = 32'(4 * i); bus.addrIn_valid = 1'b1;
      step();
    end
    bus.addrIn_valid = 1'b0;
    step(2);
    chk("skew_no_valid", 64'(vcount), 64'd0);
    for (int i = 0; i < 3; i++) begin
      bus.dataIn = 32'(i + 1); bus.dataIn_valid = 1'b1;
      step();
    end
    bus.dataIn_valid = 1'b0;
    step(3);
    chk("skew_n", 64'(pops.size()), 64'd3);
    chk_pops("skew_p0", 0, 32'h0, 32'h1);
    chk_pops("skew_p1", 1, 32'h4, 32'h2);
    chk_pops("skew_p2", 2, 32'h8, 32'h3);
    chk("skew_vcyc", 64'(vcount), 64'd3);

    // Full / backpressure
    clear_log();
    bus.stAddr_ready = 1'b0; bus.stData_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.addrIn = 32'(100 + i); bus.addrIn_valid = 1'b1;
      step();
    end
    bus.addrIn = 32'd104;
    step(2);
    chk("full_addr_ready", {63'h0, bus.addrIn_ready}, 64'd0);
    chk("full_data_ready", {63'h0, bus.dataIn_ready}, 64'd1);
    chk("full_pc_nodata", {61'h0, pairCount}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      bus.dataIn = 32'(200 + i); bus.dataIn_valid = 1'b1;
      step();
    end
    bus.dataIn = 32'd204;
    chk("both_full_pc", {61'h0, pairCount}, 64'd4);
    chk("both_full_dready", {63'h0, bus.dataIn_ready}, 64'd0);

    // Simultaneous push/pop at full: pop only, then push next cycle
    bus.stAddr_ready = 1'b1; bus.stData_ready = 1'b1;
    step();
    bus.stAddr_ready = 1'b0; bus.stData_ready = 1'b0;
    chk("pp_pc_after_pop", {61'h0, pairCount}, 64'd3);
    chk("pp_ready_after_pop", {63'h0, bus.addrIn_ready}, 64'd1);
    step();
    chk("pp_pc_after_push", {61'h0, pairCount}, 64'd4);
    bus.addrIn_valid = 1'b0; bus.dataIn_valid = 1'b0;
    chk("pp_n", 64'(pops.size()), 64'd1);
    chk_pops("pp_p0", 0, 32'd100, 32'd200);
    bus.stAddr_ready = 1'b1; bus.stData_ready = 1'b1;
    step(6);
    chk("drain_n", 64'(pops.size()), 64'd5);
    chk_pops("drain_p1", 1, 32'd101, 32'd201);
    chk_pops("drain_p4", 4, 32'd104, 32'd204);

    // Wrap: 10 continuous pairs
    clear_log();
    for (int i = 0; i < 10; i++) begin
      bus.addrIn = 32'h1000 + 32'(4 * i); bus.dataIn = 32'(3 * i + 7);
      bus.addrIn_valid = 1'b1; bus.dataIn_valid = 1'b1;
      step();
    end
    bus.addrIn_valid = 1'b0; bus.dataIn_valid = 1'b0;
    step(3);
    chk("wrap_n", 64'(pops.size()), 64'd10);
    chk("wrap_vcyc", 64'(vcount), 64'd10);
    chk("wrap_maxpc_le4", 64'(max_pc <= 4), 64'd1);
    for (int i = 0; i < 10; i++)
      chk_pops("wrap_pair", i, 32'h1000 + 32'(4 * i), 32'(3 * i + 7));

    // Reset mid-operation
    clear_log();
    bus.stAddr_ready = 1'b0; bus.stData_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.addrIn = 32'(50 + i); bus.dataIn = 32'(60 + i);
      bus.addrIn_valid = 1'b1; bus.dataIn_valid = 1'b1;
      step();
    end
    bus.addrIn_valid = 1'b0; bus.dataIn_valid = 1'b0;
    chk("mid_pc3", {61'h0, pairCount}, 64'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_readys", {62'h0, bus.addrIn_ready, bus.dataIn_ready}, 64'd0);
    chk("mid_rst_valid", {63'h0, bus.stAddr_valid}, 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("mid_after_valid", {63'h0, bus.stAddr_valid}, 64'd0);
    chk("mid_after_pc", {61'h0, pairCount}, 64'd0);
    chk("mid_after_readys", {62'h0, bus.addrIn_ready, bus.dataIn_ready}, 64'd3);
    bus.stAddr_ready = 1'b1; bus.stData_ready = 1'b1;
    bus.addrIn = 32'h77; bus.dataIn = 32'h88;
    bus.addrIn_valid = 1'b1; bus.dataIn_valid = 1'b1;
    step();
    bus.addrIn_valid = 1'b0; bus.dataIn_valid = 1'b0;
    step(3);
    chk("mid_new_n", 64'(pops.size()), 64'd1);
    chk_pops("mid_new_p0", 0, 32'h77, 32'h88);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
